// File: rtl/mem_scan_pkg.sv
// mem_scan_pkg: shared types and helpers for the RAM read-back scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_t - scanner FSM states
//   SKID_DEPTH   - output skid buffer depth (entries)
//   SKID_CNT_W   - width of the skid entry counter
//   CSUM_W       - checksum width
//   rotl1()      - rotate-left-by-one used by the checksum
package mem_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Two entries are enough to absorb the one-cycle RAM latency while the
  // issue throttle keeps a full-rate stream going.
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  localparam int CSUM_W = 32;

  function automatic logic [CSUM_W-1:0] rotl1(input logic [CSUM_W-1:0] v);
    return {v[CSUM_W-2:0], v[CSUM_W-1]};
  endfunction

endpackage

// File: rtl/mem_scan_skid.sv
// mem_scan_skid: small FIFO holding returned RAM words (data + address) until streamed out.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the owner never pushes when full nor pops when empty.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   push, push_data/addr  - write one entry
//   pop                   - drop the head entry
//   cnt                   - current number of entries
//   head_data, head_addr  - oldest entry (meaningful only when cnt != 0)
module mem_scan_skid
  import mem_scan_pkg::*;
#(
  parameter int DW = 1,
  parameter int AW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DW-1:0]         push_data,
  input  logic [AW-1:0]         push_addr,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] cnt,
  output logic [DW-1:0]         head_data,
  output logic [AW-1:0]         head_addr
);

  // Pointers wrap naturally because the depth is a power of two.
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [DW-1:0]    data_q [SKID_DEPTH];
  logic [AW-1:0]    addr_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        addr_q[wr_ptr] <= push_addr;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];

endmodule

// File: rtl/mem_readback_scanner.sv
// mem_readback_scanner: sweeps a wrapping RAM address window, streams each word and accumulates popcount + rotate-XOR checksum.
// Latency: first beat 2 cycles after the accepted start, then 1 beat/cycle while out_ready is high.
// Backpressure: out_ready low holds the current beat; read issue throttles so returned words always fit the skid.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start, start_addr,
//   count                - scan request (honoured in IDLE only)
//   raddr, rd_data       - RAM read port (registered dout, 1-cycle latency)
//   out_valid/out_ready,
//   out_addr/out_data    - output stream
//   busy, done           - scan in progress / one-cycle completion pulse
//   ones_count, checksum - accumulators over accepted beats
module mem_readback_scanner
  import mem_scan_pkg::*;
#(
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 16384,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [CNT_W-1:0]   count,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [WID_MEM-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ones_count,
  output logic [CSUM_W-1:0]  checksum
);

  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH_MEM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
  localparam int                OCC_W     = SKID_CNT_W + 1;

  scan_state_t state;

  // rd_pend: raddr holds a read the RAM samples at the coming edge.
  // rd_vld : rd_data carries the word for rv_addr this cycle.
  logic              rd_pend;
  logic              rd_vld;
  logic [ADDR_W-1:0] rv_addr;
  logic [CNT_W-1:0]  remaining;

  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [WID_MEM-1:0]    skid_data;
  logic [ADDR_W-1:0]     skid_addr;
  logic                  skid_push;
  logic                  skid_pop;

  logic             beat;
  logic [OCC_W-1:0] occ_after;
  logic             can_issue;
  logic             drained;
  logic [CNT_W-1:0] beat_ones;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // The skid head is the oldest beat; when the skid is empty, the word
  // arriving on rd_data is presented directly so the first beat costs no
  // extra cycle. An unaccepted bypass word is pushed and re-presented from
  // the skid next cycle, so the beat stays stable.
  always_comb begin
    out_valid = (skid_cnt != '0) || rd_vld;
    out_data  = '0;
    out_addr  = '0;
    if (skid_cnt != '0) begin
      out_data = skid_data;
      out_addr = skid_addr;
    end else if (rd_vld) begin
      out_data = rd_data;
      out_addr = rv_addr;
    end
  end

  always_comb begin
    beat      = out_valid && out_ready;
    skid_pop  = beat && (skid_cnt != '0);
    skid_push = rd_vld && !(beat && (skid_cnt == '0));
    // Words that will still need a home after this cycle: buffered, arriving,
    // and already requested, minus the one leaving now.
    occ_after = OCC_W'(skid_cnt) + OCC_W'(rd_pend) + OCC_W'(rd_vld) - OCC_W'(beat);
    can_issue = occ_after < OCC_W'(SKID_DEPTH);
    drained   = (occ_after == '0);
  end

  always_comb begin
    beat_ones = '0;
    for (int i = 0; i < WID_MEM; i++) begin
      beat_ones = beat_ones + CNT_W'(out_data[i]);
    end
  end

  mem_scan_skid #(
    .DW (WID_MEM),
    .AW (ADDR_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (skid_push),
    .push_data (rd_data),
    .push_addr (rv_addr),
    .pop       (skid_pop),
    .cnt       (skid_cnt),
    .head_data (skid_data),
    .head_addr (skid_addr)
  );

  // Sequencer. The first read is issued on the start edge itself so the
  // first beat lands two cycles after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      raddr     <= '0;
      rd_pend   <= 1'b0;
      rd_vld    <= 1'b0;
      rv_addr   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_vld  <= rd_pend;
      rv_addr <= raddr;
      rd_pend <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              busy      <= 1'b1;
              raddr     <= start_addr % DEPTH_A;
              rd_pend   <= 1'b1;
              remaining <= count - CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (remaining == '0) begin
            state <= ST_DRAIN;
          end else if (can_issue) begin
            raddr     <= next_addr(raddr);
            rd_pend   <= 1'b1;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Accumulators: cleared by an accepted start, then updated per accepted
  // beat; they hold their final value after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_count <= '0;
      checksum   <= '0;
    end else if ((state == ST_IDLE) && start) begin
      ones_count <= '0;
      checksum   <= '0;
    end else if (beat) begin
      ones_count <= ones_count + beat_ones;
      checksum   <= rotl1(checksum) ^ CSUM_W'(out_data);
    end
  end

endmodule

// File: tb/tb_mem_readback_scanner.sv
module tb_mem_readback_scanner;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] count = '0;
  logic [31:0] raddr;
  logic [0:0]  rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [0:0]  out_data;
  logic        busy;
  logic        done;
  logic [31:0] ones_count;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  // Observations from the last scan
  logic [31:0] beat_a[$];
  logic        beat_d[$];
  int          beat_c[$];
  int          done_cnt, done_cyc, first_vld, stab_err, timed_out;
  logic        busy_at_done;

  // Reference expectations
  logic [31:0] exp_a[$];
  logic        exp_d[$];
  logic [31:0] exp_ones, exp_csum;

  mem_readback_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .raddr      (raddr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .ones_count (ones_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle registered read, contents data[a] = a[0]
  always @(posedge clk) rd_data <= raddr[0];

  // Reference: a scan reads (start mod DEPTH + i) mod DEPTH for i < n
  task automatic model(input logic [31:0] a0, input int n);
    longint a;
    exp_a.delete();
    exp_d.delete();
    exp_ones = 0;
    exp_csum = 0;
    for (int i = 0; i < n; i++) begin
      a = (longint'(a0) % DEPTH + i) % DEPTH;
      exp_a.push_back(32'(a));
      exp_d.push_back(a % 2 == 1);
      exp_ones = exp_ones + 32'(a % 2);
      exp_csum = ((exp_csum << 1) | (exp_csum >> 31)) ^ 32'(a % 2);
    end
  endtask

  // -2: length differs, -1: identical, else first differing index
  function automatic int first_diff();
    if (beat_a.size() != exp_a.size()) return -2;
    for (int i = 0; i < beat_a.size(); i++)
      if (beat_a[i] !== exp_a[i] || beat_d[i] !== exp_d[i]) return i;
    return -1;
  endfunction

  // Pulses start, then records the stream until done + 2 cycles.
  // mode: 0 ready high, 1 toggle, 2 toggle + 5-cycle stall burst, 3 random.
  task automatic do_scan(input logic [31:0] a, input int n, input int mode,
                         input int restart_cyc, input int max_cycles);
    int cyc, burst_at;
    logic prev_hold, prev_d;
    logic [31:0] prev_a;
    @(negedge clk);
    start_addr = a;
    count = n;
    start = 1'b1;
    out_ready = 1'b1;
    beat_a.delete(); beat_d.delete(); beat_c.delete();
    done_cnt = 0; done_cyc = -1; first_vld = -1; stab_err = 0; timed_out = 0;
    busy_at_done = 1'bx;
    burst_at = $urandom_range(3, 10);
    prev_hold = 1'b0; prev_a = '0; prev_d = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_cyc);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = cyc[0];
        2: out_ready = cyc[0] && !(cyc >= burst_at && cyc < burst_at + 5);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (prev_hold && (!out_valid || out_addr !== prev_a || out_data !== prev_d)) stab_err++;
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        beat_a.push_back(out_addr);
        beat_d.push_back(out_data[0]);
        beat_c.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      prev_a = out_addr;
      prev_d = out_data[0];
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= max_cycles) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (raddr !== 32'd0) begin errors++; $display("FAIL rst_raddr got %0h want 0", raddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (ones_count !== 32'd0) begin errors++; $display("FAIL rst_ones got %0d want 0", ones_count); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL rst_csum got %0h want 0", checksum); end
    @(negedge clk);
    reset = 1'b0;
    // Asynchronous reset between edges during a running scan
    @(negedge clk);
    start_addr = 32'd5; count = 32'd8; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_async_busy got %b want 1", busy); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (raddr !== 32'd0) begin errors++; $display("FAIL async_raddr got %0h want 0", raddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++; if (ones_count !== 32'd0) begin errors++; $display("FAIL async_ones got %0d want 0", ones_count); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL async_csum got %0h want 0", checksum); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // 8 beats from address 0, with an extra start mid-scan that must be ignored
  task automatic test_basic();
    int d;
    model(32'd0, 8);
    do_scan(32'd0, 8, 0, 4, 100);
    d = first_diff();
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    checks++; if (first_vld !== 2) begin errors++; $display("FAIL basic_first_valid got %0d want 2", first_vld); end
    checks++; if (beat_a.size() !== 8) begin errors++; $display("FAIL basic_beats got %0d want 8", beat_a.size()); end
    checks++; if (d !== -1) begin errors++; $display("FAIL basic_stream first_diff got %0d want -1", d); end
    if (beat_c.size() == 8) begin
      checks++; if (beat_c[7] - beat_c[0] !== 7) begin errors++; $display("FAIL basic_b2b span got %0d want 7", beat_c[7] - beat_c[0]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulse got %0d want 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy_at_done); end
    checks++; if (ones_count !== 32'd4) begin errors++; $display("FAIL basic_ones got %0d want 4", ones_count); end
    checks++; if (checksum !== 32'h55) begin errors++; $display("FAIL basic_csum got %0h want 55", checksum); end
  endtask

  task automatic test_wrap();
    int d;
    model(32'd16382, 4);
    do_scan(32'd16382, 4, 0, -1, 100);
    d = first_diff();
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL wrap_timeout got %0d want 0", timed_out); end
    checks++; if (d !== -1) begin errors++; $display("FAIL wrap_stream first_diff got %0d want -1", d); end
    checks++; if (ones_count !== 32'd2) begin errors++; $display("FAIL wrap_ones got %0d want 2", ones_count); end
    checks++; if (checksum !== exp_csum) begin errors++; $display("FAIL wrap_csum got %0h want %0h", checksum, exp_csum); end
  endtask

  task automatic test_stall();
    int d;
    logic [31:0] a;
    a = $urandom_range(0, DEPTH - 1);
    model(a, 16);
    do_scan(a, 16, 2, -1, 300);
    d = first_diff();
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL stall_timeout got %0d want 0", timed_out); end
    checks++; if (beat_a.size() !== 16) begin errors++; $display("FAIL stall_beats got %0d want 16", beat_a.size()); end
    checks++; if (d !== -1) begin errors++; $display("FAIL stall_stream first_diff got %0d want -1", d); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
    checks++; if (ones_count !== 32'd8) begin errors++; $display("FAIL stall_ones got %0d want 8", ones_count); end
    checks++; if (checksum !== exp_csum) begin errors++; $display("FAIL stall_csum got %0h want %0h", checksum, exp_csum); end
  endtask

  task automatic test_zero();
    do_scan(32'd7, 0, 0, -1, 50);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulse got %0d want 1", done_cnt); end
    checks++; if (beat_a.size() !== 0) begin errors++; $display("FAIL zero_beats got %0d want 0", beat_a.size()); end
    checks++; if (first_vld !== -1) begin errors++; $display("FAIL zero_valid got cycle %0d want none", first_vld); end
    checks++; if (ones_count !== 32'd0) begin errors++; $display("FAIL zero_ones got %0d want 0", ones_count); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL zero_csum got %0h want 0", checksum); end
  endtask

  task automatic test_reset_mid();
    int acc, d;
    @(negedge clk);
    start_addr = 32'd0; count = 32'd8; start = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid) acc++;
    end
    checks++; if (acc !== 3) begin errors++; $display("FAIL rmid_beats got %0d want 3", acc); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (raddr !== 32'd0) begin errors++; $display("FAIL rmid_raddr got %0h want 0", raddr); end
    checks++; if (ones_count !== 32'd0) begin errors++; $display("FAIL rmid_ones got %0d want 0", ones_count); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL rmid_csum got %0h want 0", checksum); end
    @(negedge clk);
    reset = 1'b0;
    model(32'd0, 2);
    do_scan(32'd0, 2, 0, -1, 50);
    d = first_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL rmid_after_stream first_diff got %0d want -1", d); end
    checks++; if (ones_count !== 32'd1) begin errors++; $display("FAIL rmid_after_ones got %0d want 1", ones_count); end
    checks++; if (checksum !== 32'h1) begin errors++; $display("FAIL rmid_after_csum got %0h want 1", checksum); end
  endtask

  task automatic test_random();
    int d, n;
    logic [31:0] a;
    for (int it = 0; it < 12; it++) begin
      a = (it % 2 == 0) ? $urandom() : 32'(DEPTH - $urandom_range(1, 20));
      n = $urandom_range(0, 40);
      model(a, n);
      do_scan(a, n, 3, -1, 600);
      d = first_diff();
      checks++; if (timed_out !== 0 || done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done timeout %0d pulses %0d want 0/1", it, timed_out, done_cnt); end
      checks++; if (d !== -1) begin errors++; $display("FAIL rand%0d_stream first_diff got %0d want -1 (n=%0d)", it, d, n); end
      checks++; if (ones_count !== exp_ones || checksum !== exp_csum) begin errors++; $display("FAIL rand%0d_acc got %0d/%0h want %0d/%0h", it, ones_count, checksum, exp_ones, exp_csum); end
    end
  endtask

  // count larger than the memory: the scan wraps and re-reads
  task automatic test_long();
    int d;
    model(32'd16380, DEPTH + 10);
    do_scan(32'd16380, DEPTH + 10, 0, -1, DEPTH + 200);
    d = first_diff();
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL long_timeout got %0d want 0", timed_out); end
    checks++; if (d !== -1) begin errors++; $display("FAIL long_stream first_diff got %0d want -1", d); end
    checks++; if (ones_count !== exp_ones) begin errors++; $display("FAIL long_ones got %0d want %0d", ones_count, exp_ones); end
    checks++; if (checksum !== exp_csum) begin errors++; $display("FAIL long_csum got %0h want %0h", checksum, exp_csum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero();
    test_reset_mid();
    test_random();
    test_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
